fnd_scan_controller: RTL and testbench

Drives the 4-digit, common-anode 7-segment (FND) display. It accepts a 14-bit binary value and converts it to four BCD digits with an iterative double-dabble engine. It then time-multiplexes those digits onto an active-low digit-select bus and an active-low segment bus. It sits between the AXI4 register slice, which supplies the value and the on/off switch, and the board FND pins. It produces the same digit-select encoding that the 2-to-4 digit decoder consumes.

---
 rtl/fnd_scan_controller.sv | 142 ++++++++++++++
 tb/tb_fnd_scan_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND driver: 14-bit binary to BCD (iterative double-dabble)
// and time-multiplexed active-low digit/segment scan.
//
// state  | meaning
// S_IDLE | waiting for i_load; latches clamped value and clears BCD scratch
// S_CONV | 14 add-3/shift iterations, one per clock
// S_DONE | commits all four BCD digits to the display register at once
module fnd_scan_controller #(
    parameter int CLK_DIV  = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_OnOffSW,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic [3:0]  o_digit,
    output logic [7:0]  o_seg
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t        state;
    logic [13:0]   shift_q;
    logic [15:0]   bcd_q;
    logic [15:0]   bcd_adj;
    logic [15:0]   disp_q;
    logic [3:0]    iter_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] digit_sel(input logic [1:0] i);
        case (i)
            2'd0:    digit_sel = 4'b1110;
            2'd1:    digit_sel = 4'b1101;
            2'd2:    digit_sel = 4'b1011;
            default: digit_sel = 4'b0111;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            iter_q  <= '0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_load) begin
                        shift_q <= (i_value > 14'd9999) ? 14'd9999 : i_value;
                        bcd_q   <= '0;
                        iter_q  <= 4'd13;
                        o_busy  <= 1'b1;
                        state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    {bcd_q, shift_q} <= {bcd_adj[14:0], shift_q, 1'b0};
                    if (iter_q == 4'd0)
                        state <= S_DONE;
                    else
                        iter_q <= iter_q - 4'd1;
                end
                S_DONE: begin
                    disp_q <= bcd_q;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A digit above the ones place is blank when it and every higher digit are zero.
    always_comb begin
        nibble = disp_q[4*idx_q +: 4];
        case (idx_q)
            2'd1:    blank = (disp_q[15:4] == 12'd0);
            2'd2:    blank = (disp_q[15:8] == 8'd0);
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank & BLANK_LZ;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            o_digit <= 4'b1111;
            o_seg   <= 8'hFF;
        end else begin
            if (presc_q == PRESC_TC) begin
                presc_q <= '0;
                idx_q   <= idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (i_OnOffSW) begin
                o_digit <= digit_sel(idx_q);
                o_seg   <= blank ? 8'hFF : seg_code(nibble);
            end else begin
                o_digit <= 4'b1111;
                o_seg   <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: stimulus queues expected digit/segment
// pairs, a monitor matches them as each digit comes up in the scan.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst, on_sw, load;
    logic [13:0] val;
    logic        b1, b0;
    logic [3:0]  d1, d0;
    logic [7:0]  s1, s0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_OnOffSW(on_sw), .i_value(val), .i_load(load),
        .o_busy(b1), .o_digit(d1), .o_seg(s1));

    fnd_scan_controller #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_OnOffSW(on_sw), .i_value(val), .i_load(load),
        .o_busy(b0), .o_digit(d0), .o_seg(s0));

    typedef struct {
        string      name;
        bit         inst;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Cycles since reset release; the scan position follows from it directly.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [3:0] enc(input int i);
        case (i & 3)
            0:       enc = 4'b1110;
            1:       enc = 4'b1101;
            2:       enc = 4'b1011;
            default: enc = 4'b0111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_digits(input string nm, input bit inst,
                               input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0);
        sb.push_back('{name: {nm, "_d0"}, inst: inst, dig: 4'b1110, seg: e0});
        sb.push_back('{name: {nm, "_d1"}, inst: inst, dig: 4'b1101, seg: e1});
        sb.push_back('{name: {nm, "_d2"}, inst: inst, dig: 4'b1011, seg: e2});
        sb.push_back('{name: {nm, "_d3"}, inst: inst, dig: 4'b0111, seg: e3});
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_load(input int v, input int pulse_at, input int pulse_val);
        int cnt;
        @(negedge clk);
        val  = 14'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt  = 0;
        while (b1 && cnt < 40) begin
            cnt++;
            if (cnt == pulse_at) begin
                val  = 14'(pulse_val);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk($sformatf("busy_len_%0d", v), cnt, 15);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: each queued entry waits until its digit is selected, then checks the segments.
    exp_t       m_item;
    logic [3:0] m_dig;
    logic [7:0] m_seg;
    int         m_wait = 0;

    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            m_item = sb[0];
            m_dig  = m_item.inst ? d1 : d0;
            m_seg  = m_item.inst ? s1 : s0;
            if (m_item.dig == 4'b1111) begin
                chk({m_item.name, "_dig"}, 32'(m_dig), 32'(m_item.dig));
                chk({m_item.name, "_seg"}, 32'(m_seg), 32'(m_item.seg));
                void'(sb.pop_front());
                m_wait = 0;
            end else if (m_dig == m_item.dig) begin
                chk(m_item.name, 32'(m_seg), 32'(m_item.seg));
                void'(sb.pop_front());
                m_wait = 0;
            end else if (++m_wait > 64) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: digit %b never selected, last %b", m_item.name, m_item.dig, m_dig);
                void'(sb.pop_front());
                m_wait = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp42 [4];

    initial begin
        exp42 = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
        rst   = 1'b1;
        on_sw = 1'b1;
        load  = 1'b0;
        val   = '0;
        repeat (3) @(negedge clk);
        chk("rst_digit", 32'(d1), 32'hF);
        chk("rst_seg",   32'(s1), 32'hFF);
        chk("rst_busy",  32'(b1), 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("scan_%0d", i), 32'(d1), 32'(enc(i / 4)));
        end
        push_digits("zero", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        push_digits("zero_nolz", 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        drain();

        do_load(1234, -1, 0);
        push_digits("v1234", 1'b1, 8'hF9, 8'hA4, 8'hB0, 8'h99);
        drain();

        do_load(9999, -1, 0);
        push_digits("v9999", 1'b1, 8'h90, 8'h90, 8'h90, 8'h90);
        drain();
        do_load(10000, -1, 0);
        push_digits("v10000", 1'b1, 8'h90, 8'h90, 8'h90, 8'h90);
        drain();
        do_load(16383, -1, 0);
        push_digits("v16383", 1'b1, 8'h90, 8'h90, 8'h90, 8'h90);
        drain();

        do_load(507, -1, 0);
        push_digits("v0507", 1'b1, 8'hFF, 8'h92, 8'hC0, 8'hF8);
        push_digits("v0507_nolz", 1'b0, 8'hC0, 8'h92, 8'hC0, 8'hF8);
        drain();

        do_load(1234, 5, 42);
        push_digits("ign_pulse", 1'b1, 8'hF9, 8'hA4, 8'hB0, 8'h99);
        drain();
        chk("no_queued_load", 32'(b1), 32'h0);
        do_load(42, -1, 0);
        push_digits("v42", 1'b1, 8'hFF, 8'hFF, 8'h99, 8'hA4);
        drain();

        repeat (3) @(negedge clk);
        on_sw = 1'b0;
        sb.push_back('{name: "off", inst: 1'b1, dig: 4'b1111, seg: 8'hFF});
        drain();
        repeat (5) @(negedge clk);
        chk("off_hold_digit", 32'(d1), 32'hF);
        on_sw = 1'b1;
        @(negedge clk);
        chk("reon_digit", 32'(d1), 32'(enc((cyc - 1) / 4)));
        chk("reon_seg",   32'(s1), 32'(exp42[((cyc - 1) / 4) & 3]));

        @(negedge clk);
        val  = 14'd1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        chk("conv_busy", 32'(b1), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(b1), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle", 32'(b1), 32'h0);
        push_digits("abort", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
